// File: rtl/l15_data_ram_arbiter.sv
// Arbiter for the single-ported L1.5 I-cache data RAM: lookup reads have priority,
// refill writes park in a one-entry buffer and drain on idle, starved or hazard cycles.
module l15_data_ram_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_rvalid,
  output logic [DATA_WIDTH-1:0] rd_rdata,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_wdata,
  input  logic [BE_WIDTH-1:0]   wr_be,
  output logic                  wr_gnt,
  output logic                  ram_req,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [BE_WIDTH-1:0]   ram_be,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_wdata_q, wb_wdata_d;
  logic [BE_WIDTH-1:0]   wb_be_q, wb_be_d;

  logic wb_valid;
  logic force_wr;
  logic drain;
  logic load;

  // Arbitration: a buffered write only beats a read when starved or on an address hit.
  always_comb begin
    wb_valid = (state_q == HELD);
    force_wr = wb_valid & ((starve_cnt_q == STARVE_LIM) |
                           (rd_req & (rd_addr == wb_addr_q)));
    drain    = wb_valid & (~rd_req | force_wr);
    rd_gnt   = rd_req & ~force_wr;
    wr_gnt   = ~wb_valid | drain;
    load     = wr_req & wr_gnt;

    ram_req   = 1'b0;
    ram_write = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_be    = '0;
    if (drain) begin
      ram_req   = 1'b1;
      ram_write = 1'b1;
      ram_addr  = wb_addr_q;
      ram_wdata = wb_wdata_q;
      ram_be    = wb_be_q;
    end else if (rd_gnt) begin
      ram_req  = 1'b1;
      ram_addr = rd_addr;
    end
  end

  // Next state; a capture in the drain cycle reloads the buffer and keeps HELD.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wb_addr_d    = wb_addr_q;
    wb_wdata_d   = wb_wdata_q;
    wb_be_d      = wb_be_q;
    rd_pend_d    = rd_gnt;

    if (load) begin
      state_d    = HELD;
      wb_addr_d  = wr_addr;
      wb_wdata_d = wr_wdata;
      wb_be_d    = wr_be;
    end else if (drain) begin
      state_d = EMPTY;
    end

    if (load || drain || !wb_valid) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

  // Buffer payload is qualified by state_q, so it needs no reset.
  always_ff @(posedge clk) begin
    wb_addr_q  <= wb_addr_d;
    wb_wdata_q <= wb_wdata_d;
    wb_be_q    <= wb_be_d;
  end

  assign rd_rvalid = rd_pend_q;
  assign rd_rdata  = rd_pend_q ? ram_rdata : '0;

endmodule

// File: tb/tb_l15_data_ram_arbiter.sv
// Directed bench for l15_data_ram_arbiter with a simple byte-enabled RAM behind it.
module tb_l15_data_ram_arbiter;

  localparam int DW = 128;
  localparam int AW = 6;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_rvalid;
  logic [DW-1:0] rd_rdata;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_wdata;
  logic [BW-1:0] wr_be;
  logic          wr_gnt;
  logic          ram_req;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_rdata = '0;

  int total = 0;
  int bad   = 0;

  localparam logic [DW-1:0] PAT05 = {16{8'h05}};
  localparam logic [DW-1:0] PAT0A = {16{8'h0a}};
  localparam logic [DW-1:0] PAT10 = {16{8'h10}};
  localparam logic [DW-1:0] B_DAT = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DW-1:0] C_DAT = 128'hCAFE_0007_CAFE_0007_CAFE_0007_CAFE_0007;
  localparam logic [DW-1:0] D_DAT = 128'hD00D_0003_D00D_0003_D00D_0003_D00D_0003;
  localparam logic [DW-1:0] F_DAT = 128'hF00F_0009_F00F_0009_F00F_0009_F00F_0009;
  localparam logic [DW-1:0] W0    = 128'h0000_0000_0000_0000_0000_0000_0000_0A20;
  localparam logic [DW-1:0] W1    = 128'h0000_0000_0000_0000_0000_0000_0000_0B21;
  localparam logic [DW-1:0] W2    = 128'h0000_0000_0000_0000_0000_0000_0000_0C22;

  l15_data_ram_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .BE_WIDTH  (BW),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_rvalid(rd_rvalid),
    .rd_rdata (rd_rdata),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_wdata (wr_wdata),
    .wr_be    (wr_be),
    .wr_gnt   (wr_gnt),
    .ram_req  (ram_req),
    .ram_write(ram_write),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_be   (ram_be),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM: unwritten lines read back as their address repeated in every byte.
  logic [DW-1:0] mem [64];
  logic [63:0]   wr_seen = '0;

  function automatic logic [DW-1:0] init_pat(input logic [AW-1:0] a);
    return {16{{2'b00, a}}};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < BW; b++)
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_write) begin
        mem[ram_addr]     <= merge(wr_seen[ram_addr] ? mem[ram_addr] : init_pat(ram_addr),
                                   ram_wdata, ram_be);
        wr_seen[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= wr_seen[ram_addr] ? mem[ram_addr] : init_pat(ram_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_wdata = '0;
    wr_be    = '0;
    #2;
    chk("rst_rvalid", rd_rvalid, 0);
    chk("rst_rdata", rd_rdata, 0);
    chk("rst_ram_req", ram_req, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_wr_gnt", wr_gnt, 1);
    rd_req = 1'b1; rd_addr = 6'd5;
    #1;
    chk("rst_rd_gnt_follows", rd_gnt, 1);
    rd_req = 1'b0;
    cyc();
    rst_n = 1'b1;

    // Idle read of address 5
    cyc();
    rd_req = 1'b1; rd_addr = 6'd5;
    #1;
    chk("rd_gnt", rd_gnt, 1);
    chk("rd_ram_req", ram_req, 1);
    chk("rd_ram_write", ram_write, 0);
    chk("rd_ram_addr", ram_addr, 5);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("rd_rvalid", rd_rvalid, 1);
    chk("rd_rdata", rd_rdata, PAT05);
    cyc();
    #1;
    chk("rd_rvalid_off", rd_rvalid, 0);
    chk("rd_rdata_zero", rd_rdata, 0);

    // Write drains on an idle cycle
    cyc();
    wr_req = 1'b1; wr_addr = 6'd3; wr_wdata = B_DAT; wr_be = '1;
    #1;
    chk("wd_wr_gnt", wr_gnt, 1);
    chk("wd_ram_req0", ram_req, 0);
    cyc();
    wr_req = 1'b0;
    #1;
    chk("wd_ram_req", ram_req, 1);
    chk("wd_ram_write", ram_write, 1);
    chk("wd_ram_addr", ram_addr, 3);
    chk("wd_ram_wdata", ram_wdata, B_DAT);
    chk("wd_ram_be", ram_be, 16'hFFFF);
    cyc();
    #1;
    chk("wd_empty_ram_req", ram_req, 0);
    chk("wd_empty_wr_gnt", wr_gnt, 1);

    // Starvation: simultaneous read+write, then continuous reads elsewhere
    cyc();
    rd_req = 1'b1; rd_addr = 6'd10;
    wr_req = 1'b1; wr_addr = 6'd3; wr_wdata = D_DAT; wr_be = '1;
    #1;
    chk("sv_c0_rd_gnt", rd_gnt, 1);
    chk("sv_c0_wr_gnt", wr_gnt, 1);
    chk("sv_c0_ram_write", ram_write, 0);
    chk("sv_c0_ram_addr", ram_addr, 10);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      wr_req  = 1'b0;
      rd_addr = AW'(10 + i);
      #1;
      chk($sformatf("sv_c%0d_rd_gnt", i), rd_gnt, 1);
      chk($sformatf("sv_c%0d_ram_write", i), ram_write, 0);
      chk($sformatf("sv_c%0d_wr_gnt", i), wr_gnt, 0);
      if (i == 1) chk("sv_c1_rdata", rd_rdata, PAT0A);
    end
    cyc();
    rd_addr = 6'd15;
    #1;
    chk("sv_c5_rd_gnt", rd_gnt, 0);
    chk("sv_c5_ram_write", ram_write, 1);
    chk("sv_c5_ram_addr", ram_addr, 3);
    chk("sv_c5_ram_wdata", ram_wdata, D_DAT);
    chk("sv_c5_wr_gnt", wr_gnt, 1);
    cyc();
    rd_addr = 6'd16;
    #1;
    chk("sv_c6_rd_gnt", rd_gnt, 1);
    chk("sv_c6_ram_write", ram_write, 0);
    chk("sv_c6_rvalid", rd_rvalid, 0);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("sv_c7_rvalid", rd_rvalid, 1);
    chk("sv_c7_rdata", rd_rdata, PAT10);
    chk("sv_mem3", mem[3], D_DAT);

    // Read-after-write hazard on address 7
    cyc();
    wr_req = 1'b1; wr_addr = 6'd7; wr_wdata = C_DAT; wr_be = '1;
    #1;
    chk("raw_c0_wr_gnt", wr_gnt, 1);
    cyc();
    wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 6'd7;
    #1;
    chk("raw_c1_rd_gnt", rd_gnt, 0);
    chk("raw_c1_ram_write", ram_write, 1);
    chk("raw_c1_ram_addr", ram_addr, 7);
    chk("raw_c1_ram_wdata", ram_wdata, C_DAT);
    cyc();
    #1;
    chk("raw_c2_rd_gnt", rd_gnt, 1);
    chk("raw_c2_ram_write", ram_write, 0);
    chk("raw_c2_ram_addr", ram_addr, 7);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("raw_c3_rvalid", rd_rvalid, 1);
    chk("raw_c3_rdata", rd_rdata, C_DAT);

    // Back-to-back writes, no reads
    cyc();
    wr_req = 1'b1; wr_addr = 6'd20; wr_wdata = W0; wr_be = '1;
    #1;
    chk("bb_c0_wr_gnt", wr_gnt, 1);
    chk("bb_c0_ram_req", ram_req, 0);
    cyc();
    wr_addr = 6'd21; wr_wdata = W1;
    #1;
    chk("bb_c1_wr_gnt", wr_gnt, 1);
    chk("bb_c1_ram_write", ram_write, 1);
    chk("bb_c1_ram_addr", ram_addr, 20);
    chk("bb_c1_ram_wdata", ram_wdata, W0);
    cyc();
    wr_addr = 6'd22; wr_wdata = W2; wr_be = 16'h00FF;
    #1;
    chk("bb_c2_wr_gnt", wr_gnt, 1);
    chk("bb_c2_ram_addr", ram_addr, 21);
    chk("bb_c2_ram_wdata", ram_wdata, W1);
    cyc();
    wr_req = 1'b0;
    #1;
    chk("bb_c3_ram_write", ram_write, 1);
    chk("bb_c3_ram_addr", ram_addr, 22);
    chk("bb_c3_ram_wdata", ram_wdata, W2);
    chk("bb_c3_ram_be", ram_be, 16'h00FF);
    cyc();
    #1;
    chk("bb_c4_ram_req", ram_req, 0);

    // Asynchronous reset while HELD with a read pending
    cyc();
    wr_req = 1'b1; wr_addr = 6'd9; wr_wdata = F_DAT; wr_be = '1;
    rd_req = 1'b1; rd_addr = 6'd5;
    #1;
    chk("ar_c0_rd_gnt", rd_gnt, 1);
    chk("ar_c0_wr_gnt", wr_gnt, 1);
    cyc();
    wr_req = 1'b0; rd_addr = 6'd12;
    #1;
    chk("ar_c1_rvalid", rd_rvalid, 1);
    chk("ar_c1_ram_write", ram_write, 0);
    rd_req = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("ar_rvalid", rd_rvalid, 0);
    chk("ar_rdata", rd_rdata, 0);
    chk("ar_ram_req", ram_req, 0);
    chk("ar_wr_gnt", wr_gnt, 1);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk($sformatf("ar_post%0d_ram_req", i), ram_req, 0);
    end
    chk("ar_mem9_untouched", wr_seen[9], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l15_data_ram_arbiter.md
# l15_data_ram_arbiter

Shares the single-ported L1.5 instruction-cache data RAM between the lookup read path and the refill write path. Refill writes land in a one-entry write buffer and drain into the RAM in cycles the read path leaves idle. A starvation counter and a read-after-write address check force the drain when needed. The block sits directly in front of the data RAM wrapper, and its `ram_*` port drives that wrapper's req/write/addr/wdata/be/rdata pins one-to-one.

## Interface
Parameters:
- DATA_WIDTH, 128, RAM line width in bits.
- ADDR_WIDTH, 6, RAM address width.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- STARVE_MAX, 4, maximum consecutive cycles a buffered write may lose arbitration; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_req  in  1  lookup read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_gnt  out  1  read accepted this cycle.
- rd_rvalid  out  1  rd_rdata valid; asserted exactly one cycle after rd_gnt.
- rd_rdata  out  DATA_WIDTH  read data.
- wr_req  in  1  refill write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_wdata  in  DATA_WIDTH  write data.
- wr_be  in  BE_WIDTH  write byte enables.
- wr_gnt  out  1  write captured into the buffer this cycle.
- ram_req  out  1  RAM access request.
- ram_write  out  1  1 = write, 0 = read.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_be  out  BE_WIDTH  RAM byte enables.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after a read request.

## Operation
State:
- wb_valid, wb_addr, wb_wdata, wb_be: the one-entry write buffer.
- starve_cnt: width $clog2(STARVE_MAX+1), saturating.
- rd_pend: registered read grant; drives rd_rvalid.
- The block has two states. EMPTY means wb_valid=0. HELD means wb_valid=1.

Arbitration, combinational each cycle:
- Define force_wr = wb_valid & (starve_cnt == STARVE_MAX | (rd_req & rd_addr == wb_addr)).
- Define drain = wb_valid & (~rd_req | force_wr).
- rd_gnt = rd_req & ~force_wr.
- When drain is true: ram_req=1, ram_write=1, and ram_addr/ram_wdata/ram_be come from the buffer.
- Else when rd_gnt is true: ram_req=1, ram_write=0, ram_addr=rd_addr, and ram_wdata/ram_be are 0.
- Otherwise ram_req=0, and all other ram_* outputs are 0.
- wr_gnt = ~wb_valid | drain. This allows a capture in the same cycle the old entry drains.

Transitions:
- EMPTY to HELD on wr_req & wr_gnt.
- HELD to EMPTY on drain & ~wr_req.
- HELD stays HELD on drain & wr_req, which reloads the buffer with the new write.
- HELD stays HELD on ~drain, with the buffer held.
- wr_req is ignored while wr_gnt=0. The requester holds wr_req and the write fields stable until it sees wr_gnt.

starve_cnt:
- Cleared on drain, and cleared while wb_valid=0.
- Incremented while wb_valid & ~drain, saturating at STARVE_MAX.
- A freshly loaded entry always starts at 0.

Read return:
- rd_pend <= rd_gnt.
- rd_rvalid = rd_pend.
- rd_rdata = ram_rdata when rd_pend=1, else 0.

Hazard rule: a read whose address matches the buffered entry is stalled for exactly the one drain cycle. It is granted next cycle and returns the freshly written data.

## Timing
- Reset values: wb_valid=0, starve_cnt=0, rd_pend=0.
- Outputs in reset: rd_rvalid=0, rd_rdata=0, ram_req=0, ram_write=0, wr_gnt=1, and rd_gnt follows rd_req.
- Read latency: rd_gnt in cycle N gives rd_rvalid in cycle N+1. One read per cycle is sustained while no write is forced.
- Write capture takes 0 cycles (wr_gnt is combinational). The drain reaches the RAM at the earliest in the cycle after capture.
- Worst-case read stall is 1 cycle per buffered write.
- Worst-case write drain delay is STARVE_MAX+1 cycles after capture under continuous reads.
- Reset mid-operation: the buffered write is discarded and a pending rd_rvalid is dropped. The refill requester must re-issue the write.
- Simultaneous rd_req and wr_req in EMPTY: the read is granted to the RAM and the write is captured into the buffer, both in the same cycle.

## Test plan
- Idle read: rd_req=1, rd_addr=5 with RAM[5]=A -> rd_gnt=1 in cycle 0, ram_write=0, ram_addr=5; rd_rvalid=1 and rd_rdata=A in cycle 1.
- Write drain on idle: wr_req with addr=3, data=B, be='1 and no reads -> wr_gnt=1 in cycle 0; ram_req=1, ram_write=1, ram_addr=3, ram_wdata=B in cycle 1; wb_valid=0 in cycle 2.
- Starvation, STARVE_MAX=4: buffer loaded, then continuous reads to addresses other than 3 -> rd_gnt high for 4 cycles; in the 5th cycle rd_gnt=0 and the write drains; reads resume the next cycle.
- RAW hazard: buffer holds addr 7 data C, then rd_req addr 7 -> rd_gnt=0 and ram_write=1 in that cycle; rd_gnt=1 next cycle; rd_rdata=C one cycle after that.
- Back-to-back writes: wr_req held for 3 beats with no reads -> wr_gnt stays 1 each cycle, and the RAM receives 3 consecutive writes in order, each delayed by 1 cycle.
- Async reset asserted while HELD with rd_pend=1 -> rd_rvalid=0, ram_req=0, wr_gnt=1 immediately; no write reaches the RAM after reset is released.
